// File: rtl/cordic_req_arbiter.sv
// Round-robin front end that shares one pipelined sine_cosine core between NREQ clients.
// A tag line matched to the core latency routes each cos/sin pair back to its issuer.
module cordic_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int SZ      = 16,
    parameter int LAT     = 17,
    parameter int XGAIN   = 19430,
    parameter int MAX_OUT = 2
) (
    input  logic                 CLK_100MHZ,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_angle,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          cordic_angle,
    output logic [SZ-1:0]        cordic_xin,
    output logic [SZ-1:0]        cordic_yin,
    input  logic [SZ:0]          cordic_xout,
    input  logic [SZ:0]          cordic_yout,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_id,
    output logic [SZ:0]          rsp_cos,
    output logic [SZ:0]          rsp_sin,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   out_cnt_r [NREQ];
    logic [LAT:0]    tag_v_r;
    logic [2:0]      tag_id_r [LAT+1];

    logic [NREQ-1:0] elig_s;
    logic [NREQ-1:0] grant_s;
    logic            found_s;
    logic [PW-1:0]   idx_s;
    logic [PW-1:0]   gnt_id_s;
    logic [PW-1:0]   ptr_nxt_s;
    logic [31:0]     gnt_angle_s;
    logic            rel_s;
    logic [2:0]      rel_id_s;

    assign cordic_xin  = SZ'(XGAIN);
    assign cordic_yin  = {SZ{1'b0}};
    assign busy        = |tag_v_r;
    assign req_ready   = grant_s;
    assign rel_s       = tag_v_r[LAT];
    assign rel_id_s    = tag_id_r[LAT];
    assign gnt_angle_s = req_angle[{gnt_id_s, 5'b00000} +: 32];

    // Eligibility: pending request with credit left
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = req_valid[i] && (out_cnt_r[i] < CNT_MAX);
        end
    end

    // Round-robin search starting at ptr; grants are suppressed while in reset
    always_comb begin
        found_s  = 1'b0;
        gnt_id_s = '0;
        idx_s    = '0;
        grant_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = PW'((int'(ptr_r) + k) % NREQ);
            if (!found_s && elig_s[idx_s]) begin
                found_s  = 1'b1;
                gnt_id_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
        if (RST) begin
            found_s = 1'b0;
        end else begin
            grant_s[gnt_id_s] = found_s;
        end
    end

    // Pointer advance past the winner
    always_comb begin
        if (gnt_id_s == PW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_id_s + PW'(1);
        end
    end

    // Arbitration pointer and angle register feeding the core
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            ptr_r        <= '0;
            cordic_angle <= 32'h0000_0000;
        end else if (found_s) begin
            ptr_r        <= ptr_nxt_s;
            cordic_angle <= gnt_angle_s;
        end else begin
            ptr_r        <= ptr_r;
            cordic_angle <= cordic_angle;
        end
    end

    // Tag line shifts every cycle; the core cannot stall, so neither can this
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            tag_v_r <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_id_r[i] <= 3'd0;
            end
        end else begin
            tag_v_r     <= {tag_v_r[LAT-1:0], found_s};
            tag_id_r[0] <= found_s ? 3'(gnt_id_s) : 3'd0;
            for (int i = 1; i <= LAT; i++) begin
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Outstanding-sample credit per requester
    always_ff @(posedge CLK_100MHZ) begin
        for (int i = 0; i < NREQ; i++) begin
            if (RST) begin
                out_cnt_r[i] <= '0;
            end else begin
                case ({found_s && (int'(gnt_id_s) == i), rel_s && (int'(rel_id_s) == i)})
                    2'b10: begin
                        if (out_cnt_r[i] < CNT_MAX) begin
                            out_cnt_r[i] <= out_cnt_r[i] + CW'(1);
                        end else begin
                            out_cnt_r[i] <= out_cnt_r[i];
                        end
                    end
                    2'b01: begin
                        if (out_cnt_r[i] != '0) begin
                            out_cnt_r[i] <= out_cnt_r[i] - CW'(1);
                        end else begin
                            out_cnt_r[i] <= out_cnt_r[i];
                        end
                    end
                    default: out_cnt_r[i] <= out_cnt_r[i];
                endcase
            end
        end
    end

    // Response capture; payload holds while no sample is leaving
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 3'd0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
        end else begin
            rsp_valid <= rel_s;
            if (rel_s) begin
                rsp_id  <= rel_id_s;
                rsp_cos <= cordic_xout;
                rsp_sin <= cordic_yout;
            end else begin
                rsp_id  <= rsp_id;
                rsp_cos <= rsp_cos;
                rsp_sin <= rsp_sin;
            end
        end
    end
endmodule
